// File: rtl/alg_scheduler.sv
// Sample/result sequencer around the R-peak core: paces buffered ECG samples out at one per CLK_DIV cycles, queues core results.
// Latency: issue strobe one cycle after the divider reaches CLK_DIV-1; result visible at FIFO head one cycle after push.
// Backpressure: one-entry sample buffer (o_sample_ready = empty); results dropped (sticky o_overflow) only when FIFO full and not popping.
//
// Ports:
//   i_clk, i_nrst                      clock, async active-low reset
//   i_start, i_stop, o_state           control pulses and FSM state (0 IDLE, 1 WARMUP, 2 RUN, 3 STOPPING)
//   i_sample/_valid, o_sample_ready    acquisition side, valid/ready
//   o_ecg_signal/_valid, o_ce, o_ctr   core side: issued sample, strobe, clock enable, sample counter
//   i_rr_period, i_rpeak_location,
//   i_rr_period_updated                core results and push strobe
//   i_th_initialised                   core threshold ready (WARMUP -> RUN)
//   o_rr_valid, i_rr_ready,
//   o_rr_period, o_rpeak_location      result FIFO head, valid/ready
//   o_underrun, o_overflow             sticky error flags, cleared on start

// Generic synchronous FIFO with registered storage; head is combinational from the read pointer.
// Latency: one cycle from push to head.
// Backpressure: caller must not push when full unless popping in the same cycle.
module alg_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Storage is cleared so the head data reads 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end
endmodule

module alg_scheduler #(
  parameter int DATA_WIDTH = 11,
  parameter int CTR_WIDTH  = 22,
  parameter int CLK_DIV    = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_sample_valid,
  output logic                  o_sample_ready,
  output logic [DATA_WIDTH-1:0] o_ecg_signal,
  output logic                  o_ecg_signal_valid,
  output logic                  o_ce,
  output logic [CTR_WIDTH-1:0]  o_ctr,
  input  logic [CTR_WIDTH-1:0]  i_rr_period,
  input  logic [CTR_WIDTH-1:0]  i_rpeak_location,
  input  logic                  i_rr_period_updated,
  input  logic                  i_th_initialised,
  output logic                  o_rr_valid,
  input  logic                  i_rr_ready,
  output logic [CTR_WIDTH-1:0]  o_rr_period,
  output logic [CTR_WIDTH-1:0]  o_rpeak_location,
  output logic [1:0]            o_state,
  output logic                  o_underrun,
  output logic                  o_overflow
);
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WARMUP   = 2'd1,
    S_RUN      = 2'd2,
    S_STOPPING = 2'd3
  } state_t;

  state_t                  state;
  logic                    ce_q;
  logic [DIV_W-1:0]        div_q;
  logic                    buf_full;
  logic [DATA_WIDTH-1:0]   buf_dat;
  logic [DATA_WIDTH-1:0]   ecg_q;
  logic                    ecg_vld_q;
  logic [CTR_WIDTH-1:0]    ctr_q;
  logic                    underrun_q;
  logic                    overflow_q;

  logic                    go;
  logic                    active;
  logic                    tick;
  logic                    load;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push_req;
  logic                    pop;
  logic                    push;
  logic [2*CTR_WIDTH-1:0]  head;

  // Stop wins over a simultaneous start in IDLE.
  assign go       = (state == S_IDLE) && i_start && !i_stop;
  assign active   = (state == S_WARMUP) || (state == S_RUN);
  assign tick     = active && (div_q == DIV_W'(CLK_DIV - 1));
  assign load     = i_sample_valid && !buf_full;

  assign push_req = i_rr_period_updated && (state != S_IDLE);
  assign pop      = !fifo_empty && i_rr_ready;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is still accepted.
  assign push     = push_req && (!fifo_full || pop);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= S_IDLE;
      ce_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state <= S_WARMUP;
            ce_q  <= 1'b1;
          end
        end
        S_WARMUP: begin
          if (i_stop) begin
            state <= S_STOPPING;
            ce_q  <= 1'b0;
          end else if (i_th_initialised) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            state <= S_STOPPING;
            ce_q  <= 1'b0;
          end
        end
        S_STOPPING: begin
          if (fifo_empty) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          ce_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      div_q      <= '0;
      buf_full   <= 1'b0;
      buf_dat    <= '0;
      ecg_q      <= '0;
      ecg_vld_q  <= 1'b0;
      ctr_q      <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ecg_vld_q <= tick;

      // Divider only advances in WARMUP/RUN, so it holds its value in STOPPING.
      if (go) begin
        div_q      <= '0;
        ctr_q      <= '0;
        underrun_q <= 1'b0;
        overflow_q <= 1'b0;
      end else if (active) begin
        div_q <= tick ? '0 : div_q + DIV_W'(1);
      end

      if (tick) begin
        ctr_q <= ctr_q + CTR_WIDTH'(1);
        // With an empty buffer the previous sample stays on o_ecg_signal and is re-issued.
        if (buf_full) ecg_q <= buf_dat;
        else          underrun_q <= 1'b1;
      end

      // Loading is only possible when empty, so load and tick-drain never fight over buf_full.
      if (load) begin
        buf_full <= 1'b1;
        buf_dat  <= i_sample;
      end else if (tick) begin
        buf_full <= 1'b0;
      end

      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  alg_sched_fifo #(
    .WIDTH (2 * CTR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_nrst),
    .push     (push),
    .push_dat ({i_rpeak_location, i_rr_period}),
    .pop      (pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign o_sample_ready     = !buf_full;
  assign o_ecg_signal       = ecg_q;
  assign o_ecg_signal_valid = ecg_vld_q;
  assign o_ce               = ce_q;
  assign o_ctr              = ctr_q;
  assign o_rr_valid         = !fifo_empty;
  assign o_rr_period        = head[CTR_WIDTH-1:0];
  assign o_rpeak_location   = head[2*CTR_WIDTH-1:CTR_WIDTH];
  assign o_state            = state;
  assign o_underrun         = underrun_q;
  assign o_overflow         = overflow_q;
endmodule

// File: tb/tb_alg_scheduler.sv
module tb_alg_scheduler;
  localparam int DW    = 11;
  localparam int CW    = 22;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start, stop;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic [CW-1:0] rr_in, rpk_in;
  logic          upd, th, rr_ready;

  logic          sample_ready, ecg_valid, ce, rr_valid, underrun, overflow;
  logic [DW-1:0] ecg;
  logic [CW-1:0] ctr, rr_out, rpk_out;
  logic [1:0]    state;

  // Second instance with a 3-bit counter for the wrap case.
  logic          w_start;
  logic          w_ready, w_valid, w_ce, w_rr_valid, w_under, w_over;
  logic [DW-1:0] w_sig;
  logic [2:0]    w_ctr, w_rr, w_rpk;
  logic [1:0]    w_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alg_scheduler #(.DATA_WIDTH(DW), .CTR_WIDTH(CW), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) u_dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_stop(stop),
    .i_sample(sample), .i_sample_valid(sample_valid), .o_sample_ready(sample_ready),
    .o_ecg_signal(ecg), .o_ecg_signal_valid(ecg_valid), .o_ce(ce), .o_ctr(ctr),
    .i_rr_period(rr_in), .i_rpeak_location(rpk_in), .i_rr_period_updated(upd),
    .i_th_initialised(th), .o_rr_valid(rr_valid), .i_rr_ready(rr_ready),
    .o_rr_period(rr_out), .o_rpeak_location(rpk_out), .o_state(state),
    .o_underrun(underrun), .o_overflow(overflow)
  );

  alg_scheduler #(.DATA_WIDTH(DW), .CTR_WIDTH(3), .CLK_DIV(2), .FIFO_DEPTH(2)) u_wrap (
    .i_clk(clk), .i_nrst(nrst), .i_start(w_start), .i_stop(1'b0),
    .i_sample('0), .i_sample_valid(1'b0), .o_sample_ready(w_ready),
    .o_ecg_signal(w_sig), .o_ecg_signal_valid(w_valid), .o_ce(w_ce), .o_ctr(w_ctr),
    .i_rr_period(3'd0), .i_rpeak_location(3'd0), .i_rr_period_updated(1'b0),
    .i_th_initialised(1'b0), .o_rr_valid(w_rr_valid), .i_rr_ready(1'b0),
    .o_rr_period(w_rr), .o_rpeak_location(w_rpk), .o_state(w_state),
    .o_underrun(w_under), .o_overflow(w_over)
  );

  // Reference model: state number, active-edge count since start, buffer, last issued sample, results queue.
  int              m_state;
  int              m_n;
  bit              m_full;
  logic [DW-1:0]   m_buf, m_last;
  logic [CW-1:0]   m_ctr;
  bit              m_strobe, m_under, m_over;
  logic [2*CW-1:0] m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_n = 0; m_full = 0; m_buf = '0; m_last = '0; m_ctr = '0;
    m_strobe = 0; m_under = 0; m_over = 0;
    m_q.delete();
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, sample_ready, 1);
    chk({tag, "_ecg"}, ecg, 0);
    chk({tag, "_ecg_valid"}, ecg_valid, 0);
    chk({tag, "_ce"}, ce, 0);
    chk({tag, "_ctr"}, ctr, 0);
    chk({tag, "_rr_valid"}, rr_valid, 0);
    chk({tag, "_rr"}, rr_out, 0);
    chk({tag, "_rpk"}, rpk_out, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  // One clock: advance the model by the rules for this edge, then compare every output.
  task automatic step();
    bit              act, tick, load, pop, push_req;
    int              size0;
    logic [2*CW-1:0] h;
    @(posedge clk);
    size0 = m_q.size();
    act   = (m_state == 1) || (m_state == 2);
    tick  = act && ((m_n + 1) % DIV == 0);
    load  = sample_valid && !m_full;
    if (act) m_n++;
    m_strobe = tick;
    if (tick) begin
      m_ctr++;
      if (m_full) begin m_last = m_buf; m_full = 0; end
      else m_under = 1;
    end
    if (load) begin m_buf = sample; m_full = 1; end
    pop      = (size0 > 0) && rr_ready;
    push_req = upd && (m_state != 0);
    if (pop) void'(m_q.pop_front());
    if (push_req) begin
      if (size0 < DEPTH || pop) m_q.push_back({rpk_in, rr_in});
      else m_over = 1;
    end
    case (m_state)
      0: if (start && !stop) begin m_state = 1; m_n = 0; m_ctr = '0; m_under = 0; m_over = 0; end
      1: if (stop) m_state = 3; else if (th) m_state = 2;
      2: if (stop) m_state = 3;
      default: if (size0 == 0) m_state = 0;
    endcase
    #1;
    chk("state", state, m_state);
    chk("ecg_valid", ecg_valid, m_strobe);
    chk("ecg", ecg, m_last);
    chk("ctr", ctr, m_ctr);
    chk("ce", ce, (m_state == 1 || m_state == 2));
    chk("sample_ready", sample_ready, !m_full);
    chk("underrun", underrun, m_under);
    chk("overflow", overflow, m_over);
    chk("rr_valid", rr_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      h = m_q[0];
      chk("head_rr", rr_out, h[CW-1:0]);
      chk("head_rpk", rpk_out, h[2*CW-1:CW]);
    end
  endtask

  task automatic push_rr(input logic [CW-1:0] rr);
    rr_in = rr; rpk_in = CW'($urandom); upd = 1; step(); upd = 0;
  endtask

  initial begin
    nrst = 0; start = 0; stop = 0; sample = '0; sample_valid = 0;
    rr_in = '0; rpk_in = '0; upd = 0; th = 0; rr_ready = 0; w_start = 0;
    model_reset();
    #3 check_reset("reset");
    #4 nrst = 1;

    // Pre-load a sample in IDLE, then start.
    sample = DW'($urandom); sample_valid = 1; step(); sample_valid = 0;
    chk("preload_ready", sample_ready, 0);
    start = 1; step(); start = 0;
    chk("warmup_state", state, 1);

    // Continuously offered samples: strobe every DIV cycles, counter 1,2,3...
    for (int i = 0; i < 24; i++) begin
      sample = DW'($urandom); sample_valid = 1; step();
    end
    sample_valid = 0;
    chk("fed_no_underrun", underrun, 0);

    // Issue 0x123, then withhold: the next strobe repeats 0x123 and flags underrun.
    for (int i = 0; i < 2 * DIV; i++) begin
      if (!m_full) break;
      step();
    end
    chk("buffer_drained", sample_ready, 1);
    sample = 11'h123; sample_valid = 1; step(); sample_valid = 0;
    repeat (2 * DIV) step();
    chk("repeat_sample", ecg, 11'h123);
    chk("underrun_set", underrun, 1);
    sample = DW'($urandom); sample_valid = 1; step(); sample_valid = 0;
    repeat (DIV) step();
    chk("underrun_sticky", underrun, 1);

    // WARMUP -> RUN, then three results held at the head until ready.
    th = 1; step(); th = 0;
    chk("run_state", state, 2);
    push_rr(22'd250); push_rr(22'd260); push_rr(22'd255);
    repeat (3) step();
    chk("head_held", rr_out, 250);
    rr_ready = 1;
    step(); chk("pop_order_2", rr_out, 260);
    step(); chk("pop_order_3", rr_out, 255);
    step(); chk("drained", rr_valid, 0);
    rr_ready = 0;

    // Fill, push-with-pop on full (accepted), then a drop on full.
    repeat (DEPTH) push_rr(CW'($urandom));
    chk("full_no_overflow", overflow, 0);
    rr_ready = 1; push_rr(CW'($urandom)); rr_ready = 0;
    chk("push_pop_full", overflow, 0);
    push_rr(CW'($urandom));
    chk("overflow_set", overflow, 1);
    rr_ready = 1; step(); step(); rr_ready = 0;

    // Stop in RUN with two entries: STOPPING until both are popped, then IDLE.
    for (int i = 0; i < DIV; i++) begin
      if ((m_n + 1) % DIV != 0) break;
      step();
    end
    stop = 1; step(); stop = 0;
    chk("stopping_state", state, 3);
    chk("stopping_ce", ce, 0);
    repeat (2 * DIV) step();
    chk("stopping_hold", state, 3);
    rr_ready = 1; step(); step(); step(); rr_ready = 0;
    chk("back_to_idle", state, 0);

    // Start and stop together in IDLE: stop wins.
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("start_stop_idle", state, 0);

    // Randomised traffic against the model.
    start = 1; step(); start = 0;
    for (int i = 0; i < 240; i++) begin
      sample_valid = ($urandom % 4) != 0;
      sample       = DW'($urandom);
      upd          = ($urandom % 3) == 0;
      rr_in        = CW'($urandom);
      rpk_in       = CW'($urandom);
      rr_ready     = ($urandom % 2) == 1;
      th           = ($urandom % 16) == 0;
      stop         = ($urandom % 64) == 0;
      start        = ($urandom % 8) == 0;
      step();
    end
    sample_valid = 0; upd = 0; rr_ready = 0; th = 0; stop = 0; start = 0;
    repeat (2) step();

    // Reset in the middle of RUN clears everything.
    for (int i = 0; i < 40; i++) begin
      if (m_state == 0) break;
      stop = 1; rr_ready = 1; step();
    end
    stop = 0; rr_ready = 0;
    start = 1; step(); start = 0;
    th = 1; step(); th = 0;
    push_rr(CW'($urandom));
    sample = DW'($urandom); sample_valid = 1; step(); sample_valid = 0;
    repeat (DIV + 1) step();
    chk("pre_reset_run", state, 2);
    #2 nrst = 0;
    #1 check_reset("mid_reset");
    model_reset();
    #2 nrst = 1;
    repeat (3) step();

    // Counter wrap on the 3-bit instance: strobe every 2 cycles, ctr = j mod 8.
    w_start = 1; step(); w_start = 0;
    chk("wrap_state", w_state, 1);
    for (int j = 1; j <= 10; j++) begin
      step(); chk("wrap_gap", w_valid, 0);
      step(); chk("wrap_strobe", w_valid, 1);
      chk("wrap_ctr", w_ctr, j % 8);
    end
    chk("wrap_underrun", w_under, 1);
    chk("wrap_rr_valid", w_rr_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
